fpu_fma_sequencer: RTL and testbench
====================================

FPU_FMA_SEQUENCER -- requirements
Module: fpu_fma_sequencer

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- MUL_CYCLES, 1, cycles the multiplier stage is held before its product is sampled (legal: 1 or more).
- ADD_CYCLES, 1, cycles the adder stage is held before its sum is sampled (legal: 1 or more).

REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  96  requester 0 operands {a,b,c}; each is a packed IEEE-754 single (sign,exp[7:0],mantissa[22:0]).
- req1_valid, req1_ready, req1_op: as requester 0, for requester 1.
- mul_a  out  32  multiplier operand 1.
- mul_b  out  32  multiplier operand 2.
- mul_p  in  32  multiplier product, packed single.
- add_x  out  32  adder operand 1.
- add_y  out  32  adder operand 2.
- add_s  in  32  adder sum, packed single.
- add_invalid  in  1  adder invalid flag.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  1  requester that issued the result.
- rsp_result  out  32  a*b+c.
- rsp_invalid  out  1  captured add_invalid.
- busy  out  1  high in any state other than IDLE.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, MUL, ADD, DONE.

REQ-004 IDLE arbitration:
- If exactly one requester has valid high, that requester SHALL be granted.
- If both have valid high, the requester not granted last SHALL be granted (round-robin).

REQ-005 reqN_ready SHALL be high only in IDLE, only for the granted requester, and combinationally from reqN_valid and the arbitration; the other requester's ready SHALL be low.

REQ-006 On transfer (valid and ready both high):
- The operands and the requester id SHALL be latched.
- The last-grant pointer SHALL be updated.
- The counter SHALL be loaded with MUL_CYCLES-1.
- The FSM SHALL go to MUL.

REQ-007 In MUL:
- mul_a and mul_b SHALL drive the latched a and b.
- The counter SHALL decrement each cycle.
- In the cycle the counter is 0, mul_p SHALL be registered into the product register, the counter SHALL be loaded with ADD_CYCLES-1, and the FSM SHALL go to ADD.

REQ-008 In ADD:
- add_x SHALL drive the product register and add_y SHALL drive the latched c.
- In the cycle the counter is 0, add_s and add_invalid SHALL be registered into rsp_result and rsp_invalid, and the FSM SHALL go to DONE.

REQ-009 mul_a and mul_b SHALL be 0 outside MUL; add_x and add_y SHALL be 0 outside ADD.

REQ-010 In DONE:
- rsp_valid SHALL be high.
- rsp_id, rsp_result and rsp_invalid SHALL be held stable until rsp_ready is sampled high.
- After the rsp_ready handshake the FSM SHALL go to IDLE.
- No new request SHALL be accepted in the same cycle as the rsp_ready handshake.

REQ-011 Latency: for a transfer in cycle T, rsp_valid SHALL first be high in cycle T+MUL_CYCLES+ADD_CYCLES+1.

REQ-012 Only mul_p and add_s values present on a stage's final cycle SHALL affect the result; values on earlier cycles are ignored.

REQ-013 A requester's valid dropping while it is not granted SHALL have no effect, and no operation SHALL be lost or duplicated.

REQ-014 The block SHALL perform no arithmetic itself; the operand and result widths are fixed at 32 bits per value.

Reset
REQ-015 When rst is high at a clock edge, the block SHALL reset as follows:
- state = IDLE;
- counter = 0;
- all registered outputs and internal registers = 0;
- last-grant pointer set so that requester 0 wins the first contention.

REQ-016 A reset asserted in MUL, ADD or DONE SHALL abandon the operation; no response SHALL be produced for it.

REQ-017 With req0_valid already high, reqN_ready SHALL be able to assert in the first cycle after rst deasserts.

Verification
REQ-018 Single op, defaults: req0 transfers at T with a=0x40000000, b=0x40400000, c=0x3F800000; the model returns mul_p=0x40C00000 and add_s=0x40E00000 -> in cycle T+3, rsp_valid=1, rsp_id=0, rsp_result=0x40E00000, rsp_invalid=0.

REQ-019 Contention: both valid high continuously from reset for 4 operations -> grants are 0,1,0,1; ready is never high for both requesters in the same cycle.

REQ-020 Backpressure: rsp_ready held low for 5 cycles in DONE -> rsp_* outputs stay stable; req0_ready and req1_ready stay 0; IDLE is re-entered one cycle after rsp_ready rises.

REQ-021 MUL_CYCLES=3, ADD_CYCLES=2: mul_p changes from 0x11111111 to 0x40C00000 on the last MUL cycle -> the product register holds 0x40C00000, add_x = 0x40C00000, and rsp_valid rises at T+6.

REQ-022 Reset mid-ADD -> rsp_valid stays 0, busy=0 the next cycle; a subsequent req1 operation completes normally with rsp_id=1.

REQ-023 add_invalid=1 on the final ADD cycle (add_s=0x7FC00000) -> rsp_invalid=1 and rsp_result=0x7FC00000.

Source files
------------

// File: rtl/fpu_fma_sequencer.sv
// Sequences one fused a*b+c through external multiplier and adder units,
// arbitrating round-robin between two requesters.
module fpu_fma_sequencer #(
  parameter int MUL_CYCLES = 1,
  parameter int ADD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [95:0] req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [95:0] req1_op,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_p,
  output logic [31:0] add_x,
  output logic [31:0] add_y,
  input  logic [31:0] add_s,
  input  logic        add_invalid,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_invalid,
  output logic        busy
);
  localparam int CMAX = (MUL_CYCLES > ADD_CYCLES) ? MUL_CYCLES : ADD_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] MUL_LD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] ADD_LD = CW'(ADD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          id_q, id_d;
  logic [31:0]   a_q, a_d, b_q, b_d, c_q, c_d;
  logic [31:0]   prod_q, prod_d, res_q, res_d;
  logic          inv_q, inv_d;
  logic          gnt0, gnt1;
  logic [95:0]   op_sel;

  // last_q names the requester granted most recently; the other one wins ties.
  assign gnt0   = req0_valid & (~req1_valid | last_q);
  assign gnt1   = req1_valid & (~req0_valid | ~last_q);
  assign op_sel = gnt1 ? req1_op : req0_op;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      prod_q  <= '0;
      res_q   <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      prod_q  <= prod_d;
      res_q   <= res_d;
      inv_q   <= inv_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    id_d       = id_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    prod_d     = prod_q;
    res_d      = res_q;
    inv_d      = inv_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    mul_a      = '0;
    mul_b      = '0;
    add_x      = '0;
    add_y      = '0;
    case (state_q)
      IDLE: begin
        req0_ready = gnt0;
        req1_ready = gnt1;
        if (gnt0 | gnt1) begin
          a_d     = op_sel[95:64];
          b_d     = op_sel[63:32];
          c_d     = op_sel[31:0];
          id_d    = gnt1;
          last_d  = gnt1;
          cnt_d   = MUL_LD;
          state_d = MUL;
        end
      end
      MUL: begin
        mul_a = a_q;
        mul_b = b_q;
        if (cnt_q == '0) begin
          prod_d  = mul_p;
          cnt_d   = ADD_LD;
          state_d = ADD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ADD: begin
        add_x = prod_q;
        add_y = c_q;
        if (cnt_q == '0) begin
          res_d   = add_s;
          inv_d   = add_invalid;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_valid   = (state_q == DONE);
  assign rsp_id      = id_q;
  assign rsp_result  = res_q;
  assign rsp_invalid = inv_q;
  assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_fpu_fma_sequencer.sv
// Bench: directed scenarios on a default and a (3,2) instance, then a random
// run against a cycle-offset reference model of the sequencer.
module tb_fpu_fma_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req0_valid, req0_ready, req1_valid, req1_ready;
  logic [95:0] req0_op, req1_op;
  logic [31:0] mul_a, mul_b, mul_p, add_x, add_y, add_s, rsp_result;
  logic        add_invalid, rsp_valid, rsp_ready, rsp_id, rsp_invalid, busy;

  logic        rst1, q_req0_valid, q_req0_ready, q_req1_valid, q_req1_ready;
  logic [95:0] q_req0_op, q_req1_op;
  logic [31:0] q_mul_a, q_mul_b, q_mul_p, q_add_x, q_add_y, q_add_s, q_rsp_result;
  logic        q_add_invalid, q_rsp_valid, q_rsp_ready, q_rsp_id, q_rsp_invalid, q_busy;

  fpu_fma_sequencer u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .add_x(add_x), .add_y(add_y), .add_s(add_s), .add_invalid(add_invalid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_invalid(rsp_invalid), .busy(busy)
  );

  fpu_fma_sequencer #(.MUL_CYCLES(3), .ADD_CYCLES(2)) u_dut32 (
    .clk(clk), .rst(rst1),
    .req0_valid(q_req0_valid), .req0_ready(q_req0_ready), .req0_op(q_req0_op),
    .req1_valid(q_req1_valid), .req1_ready(q_req1_ready), .req1_op(q_req1_op),
    .mul_a(q_mul_a), .mul_b(q_mul_b), .mul_p(q_mul_p),
    .add_x(q_add_x), .add_y(q_add_y), .add_s(q_add_s), .add_invalid(q_add_invalid),
    .rsp_valid(q_rsp_valid), .rsp_ready(q_rsp_ready), .rsp_id(q_rsp_id),
    .rsp_result(q_rsp_result), .rsp_invalid(q_rsp_invalid), .busy(q_busy)
  );

  localparam logic [31:0] A = 32'h40000000, B = 32'h40400000, C = 32'h3F800000;
  localparam logic [31:0] P = 32'h40C00000, S = 32'h40E00000, QNAN = 32'h7FC00000;

  int checks = 0, errors = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // reference model state for the random phase
  bit          m_act, m_last, m_id, m_inv, g0, g1, clr0, clr1;
  int          m_t0, k, n_xfer, n_rsp, n_gnt;
  logic [31:0] m_a, m_b, m_c, m_p, m_s;
  bit          gnt_seq [4];

  initial begin
    rst = 1'b1; rst1 = 1'b1;
    req0_valid = 0; req1_valid = 0; req0_op = '0; req1_op = '0;
    mul_p = '0; add_s = '0; add_invalid = 0; rsp_ready = 0;
    q_req0_valid = 0; q_req1_valid = 0; q_req0_op = '0; q_req1_op = '0;
    q_mul_p = '0; q_add_s = '0; q_add_invalid = 0; q_rsp_ready = 0;
    tick(); tick();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_inv", rsp_invalid, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_add_x", add_x, 0);
    chk("rst_q_busy", q_busy, 0);

    // (3,2) instance: early mul_p / add_s garbage must be ignored
    q_req0_valid = 1; q_req0_op = {A, B, C};
    rst1 = 1'b0;
    #1;
    chk("q_ready0", q_req0_ready, 1);
    chk("q_ready1", q_req1_ready, 0);
    tick();
    q_req0_valid = 0;
    for (int kk = 1; kk <= 6; kk++) begin
      q_mul_p = (kk == 3) ? P : 32'h11111111;
      q_add_s = (kk == 5) ? S : 32'h22222222;
      q_add_invalid = (kk == 4);
      #1;
      chk("q_busy", q_busy, 1);
      chk("q_rsp_valid", q_rsp_valid, kk == 6);
      chk("q_mul_a", q_mul_a, (kk <= 3) ? A : 32'h0);
      chk("q_mul_b", q_mul_b, (kk <= 3) ? B : 32'h0);
      chk("q_add_x", q_add_x, (kk == 4 || kk == 5) ? P : 32'h0);
      chk("q_add_y", q_add_y, (kk == 4 || kk == 5) ? C : 32'h0);
      if (kk == 6) begin
        chk("q_rsp_result", q_rsp_result, S);
        chk("q_rsp_inv", q_rsp_invalid, 0);
        chk("q_rsp_id", q_rsp_id, 0);
        q_rsp_ready = 1;
      end
      tick();
    end
    #1;
    chk("q_idle", q_busy, 0);

    // default instance: ready in the first cycle out of reset, single op
    req0_valid = 1; req0_op = {A, B, C};
    rst = 1'b0;
    #1;
    chk("t0_ready0", req0_ready, 1);
    chk("t0_ready1", req1_ready, 0);
    tick();
    req0_op = {$urandom, $urandom, $urandom}; req1_valid = 1; req1_op = {C, A, B};
    mul_p = P;
    #1;
    chk("t1_mul_a", mul_a, A);
    chk("t1_mul_b", mul_b, B);
    chk("t1_add_x", add_x, 0);
    chk("t1_ready0", req0_ready, 0);
    chk("t1_ready1", req1_ready, 0);
    tick();
    mul_p = 32'h0BAD0BAD; add_s = S; add_invalid = 0;
    #1;
    chk("t2_add_x", add_x, P);
    chk("t2_add_y", add_y, C);
    chk("t2_mul_a", mul_a, 0);
    chk("t2_rsp_valid", rsp_valid, 0);
    tick();
    // back-pressure: five cycles with rsp_ready low
    for (int j = 0; j < 5; j++) begin
      add_s = $urandom; add_invalid = 1'($urandom_range(1));
      #1;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_id", rsp_id, 0);
      chk("bp_result", rsp_result, S);
      chk("bp_inv", rsp_invalid, 0);
      chk("bp_ready0", req0_ready, 0);
      chk("bp_ready1", req1_ready, 0);
      tick();
    end
    rsp_ready = 1;
    #1;
    chk("hs_valid", rsp_valid, 1);
    chk("hs_ready1", req1_ready, 0);
    tick();
    rsp_ready = 0;
    #1;
    chk("hs_idle", busy, 0);
    chk("rr_ready1", req1_ready, 1);
    chk("rr_ready0", req0_ready, 0);
    tick();
    req0_valid = 0;
    tick();
    rst = 1'b1;                // mid-ADD
    tick();
    rst = 1'b0;
    req1_op = {QNAN, A, B};
    #1;
    chk("ra_busy", busy, 0);
    chk("ra_rsp_valid", rsp_valid, 0);
    chk("ra_ready1", req1_ready, 1);
    tick();
    req1_valid = 0; mul_p = 32'h7F800000;
    tick();
    add_s = QNAN; add_invalid = 1;
    #1;
    chk("ra_add_x", add_x, 32'h7F800000);
    chk("ra_add_y", add_y, B);
    tick();
    add_invalid = 0; add_s = 0;
    #1;
    chk("inv_valid", rsp_valid, 1);
    chk("inv_id", rsp_id, 1);
    chk("inv_result", rsp_result, QNAN);
    chk("inv_flag", rsp_invalid, 1);
    rsp_ready = 1;
    tick();
    #1;
    chk("inv_idle", busy, 0);

    // contention from reset: grants alternate starting with requester 0
    rst = 1'b1; req0_valid = 1; req1_valid = 1;
    tick();
    rst = 1'b0;
    n_gnt = 0;
    for (int j = 0; j < 60 && n_gnt < 4; j++) begin
      mul_p = $urandom; add_s = $urandom;
      #1;
      chk("ct_not_both", req0_ready & req1_ready, 0);
      if (req0_ready | req1_ready) begin
        gnt_seq[n_gnt] = req1_ready;
        n_gnt++;
      end
      tick();
    end
    chk("ct_count", n_gnt, 4);
    for (int j = 0; j < 4; j++) chk("ct_grant", gnt_seq[j], j % 2);

    // random phase against the reference model
    rst = 1'b1; req0_valid = 0; req1_valid = 0;
    tick();
    rst = 1'b0;
    m_act = 0; m_last = 1; n_xfer = 0; n_rsp = 0;
    for (int i = 0; i < 400; i++) begin
      clr0 = 0; clr1 = 0;
      if (req0_valid) begin
        if ($urandom_range(7) == 0) req0_valid = 0;
      end else if ($urandom_range(1) == 1) begin
        req0_valid = 1; req0_op = {$urandom, $urandom, $urandom};
      end
      if (req1_valid) begin
        if ($urandom_range(7) == 0) req1_valid = 0;
      end else if ($urandom_range(1) == 1) begin
        req1_valid = 1; req1_op = {$urandom, $urandom, $urandom};
      end
      rsp_ready = 1'($urandom_range(1));
      mul_p = $urandom; add_s = $urandom; add_invalid = 1'($urandom_range(1));
      k = cyc - m_t0;
      if (m_act && k == 1) mul_p = m_p;
      if (m_act && k == 2) begin add_s = m_s; add_invalid = m_inv; end
      #1;
      if (!m_act) begin
        g0 = req0_valid && (!req1_valid || m_last);
        g1 = req1_valid && (!req0_valid || !m_last);
        chk("rnd_ready0", req0_ready, g0);
        chk("rnd_ready1", req1_ready, g1);
        chk("rnd_busy", busy, 0);
        chk("rnd_rsp_valid", rsp_valid, 0);
        chk("rnd_mul_a", mul_a, 0);
        chk("rnd_add_x", add_x, 0);
        if (g0 || g1) begin
          m_act = 1; m_t0 = cyc; m_id = g1; m_last = g1;
          {m_a, m_b, m_c} = g1 ? req1_op : req0_op;
          m_p = $urandom; m_s = $urandom; m_inv = 1'($urandom_range(1));
          n_xfer++;
          clr0 = g0; clr1 = g1;
        end
      end else begin
        chk("rnd_b_ready0", req0_ready, 0);
        chk("rnd_b_ready1", req1_ready, 0);
        chk("rnd_b_busy", busy, 1);
        chk("rnd_mul_a", mul_a, (k == 1) ? m_a : 32'h0);
        chk("rnd_mul_b", mul_b, (k == 1) ? m_b : 32'h0);
        chk("rnd_add_x", add_x, (k == 2) ? m_p : 32'h0);
        chk("rnd_add_y", add_y, (k == 2) ? m_c : 32'h0);
        chk("rnd_rsp_valid", rsp_valid, k >= 3);
        if (k >= 3) begin
          chk("rnd_rsp_id", rsp_id, m_id);
          chk("rnd_rsp_result", rsp_result, m_s);
          chk("rnd_rsp_inv", rsp_invalid, m_inv);
          if (rsp_ready) begin
            m_act = 0;
            n_rsp++;
          end
        end
      end
      tick();
      if (clr0) req0_valid = 0;
      if (clr1) req1_valid = 0;
    end
    chk("rnd_no_loss", n_rsp, n_xfer - int'(m_act));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
